// File: rtl/prefix_adder_pipe.sv
// Pipelined add/sub unit built on a Kogge-Stone carry prefix over kgp codes.
// Code position 0 holds the effective carry-in; position i+1 holds operand bit i.
// A register bank follows every REG_EVERY prefix levels; the last bank forms
// the sum and flags. A global stall freezes every bank, so bubbles are kept.
module prefix_adder_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = (LEVELS + REG_EVERY - 1) / REG_EVERY + 1;
    localparam int NSTG   = LAT - 1;

    localparam logic [1:0] KILL = 2'b00;
    localparam logic [1:0] PROP = 2'b01;
    localparam logic [1:0] GEN  = 2'b11;

    typedef logic [WIDTH:0][1:0] kgp_vec_t;

    kgp_vec_t         code_in;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    kgp_vec_t         code_q [NSTG];
    logic [WIDTH-1:0] hx_q   [NSTG];
    logic [TAG_W-1:0] tag_q  [NSTG];
    logic [NSTG-1:0]  vld_q;

    kgp_vec_t         lvl_out [LEVELS];
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             stall;

    // Upper span propagating means the lower span decides.
    function automatic logic [1:0] kgp_op(input logic [1:0] hi, input logic [1:0] lo);
        return (hi == PROP) ? lo : hi;
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Operand conditioning and per-bit kgp codes for the first bank.
    always_comb begin
        b_eff      = b ^ {WIDTH{sub}};
        cin_eff    = sub | cin;
        code_in    = '0;
        code_in[0] = cin_eff ? GEN : KILL;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i] & b_eff[i])
                code_in[i+1] = GEN;
            else if (a[i] ^ b_eff[i])
                code_in[i+1] = PROP;
            else
                code_in[i+1] = KILL;
        end
    end

    // Prefix levels; a level starting a new group reads its bank register.
    always_comb begin
        kgp_vec_t cur;
        kgp_vec_t nxt;
        cur = code_q[0];
        nxt = cur;
        for (int k = 0; k < LEVELS; k++) begin
            if (k % REG_EVERY == 0)
                cur = code_q[k / REG_EVERY];
            nxt = cur;
            for (int j = (1 << k); j <= WIDTH; j++)
                nxt[j] = kgp_op(cur[j], cur[j - (1 << k)]);
            lvl_out[k] = nxt;
            cur        = nxt;
        end
    end

    // Carries: the top span stops one short of the carry-in, so a span left
    // in propagate inherits the carry-in directly.
    always_comb begin
        kgp_vec_t fin;
        fin = lvl_out[LEVELS-1];
        for (int i = 0; i < WIDTH; i++)
            carry[i] = (fin[i+1] == GEN) | ((fin[i+1] == PROP) & fin[0][1]);
        sum_d = hx_q[NSTG-1] ^ {carry[WIDTH-2:0], fin[0][1]};
    end

    // Pipeline banks with global stall; reset wins over stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < NSTG; s++) begin
                code_q[s] <= '0;
                hx_q[s]   <= '0;
                tag_q[s]  <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            tag_out   <= '0;
        end else if (!stall) begin
            vld_q[0]  <= in_valid;
            code_q[0] <= code_in;
            hx_q[0]   <= a ^ b_eff;
            tag_q[0]  <= tag_in;
            for (int s = 1; s < NSTG; s++) begin
                vld_q[s]  <= vld_q[s-1];
                code_q[s] <= lvl_out[s*REG_EVERY - 1];
                hx_q[s]   <= hx_q[s-1];
                tag_q[s]  <= tag_q[s-1];
            end
            out_valid <= vld_q[NSTG-1];
            sum       <= sum_d;
            cout      <= carry[WIDTH-1];
            ovf       <= carry[WIDTH-1] ^ carry[WIDTH-2];
            zero      <= (sum_d == '0);
            tag_out   <= tag_q[NSTG-1];
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench: one directed 32-bit instance plus six swept configurations, each
// checked every cycle against an arithmetic reference queue.
module tb_prefix_adder_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int sweep_done = 0;
    int consumed_cnt [7] = '{default: 0};

    logic        m_rst_n, sw_rst_n;
    logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready;
    logic        m_cout, m_ovf, m_zero;
    logic [31:0] m_a, m_b, m_sum;
    logic [3:0]  m_tag, m_tag_out;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [7:0]  tag;
        int          acc;
        int          snap;
    } exp_t;

    // Reference result from plain modular arithmetic and sign rules.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub,
                                   input logic [7:0] tag, input int w);
        exp_t        r;
        logic [64:0] full;
        logic [63:0] mask;
        logic        sa, sb, ss;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a & mask;
        b = b & mask;
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b};
            r.cout = (a >= b);
        end else begin
            full   = {1'b0, a} + {1'b0, b} + 65'(cin);
            r.cout = full[w];
        end
        r.sum  = full[63:0] & mask;
        sa     = a[w-1];
        sb     = b[w-1];
        ss     = r.sum[w-1];
        r.ovf  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        r.zero = (r.sum == 64'd0);
        r.tag  = tag;
        r.acc  = 0;
        r.snap = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [cfg %0d] actual=%0h required=%0h", nm, id, act, exp);
        end
    endtask

    for (genvar g = 0; g < 7; g++) begin : cfg
        localparam int W    = (g == 0) ? 32 : (4 << (2 * ((g - 1) / 2)));
        localparam int LV   = $clog2(W);
        localparam int RE   = (g == 0) ? 2 : (((g - 1) % 2 == 0) ? 1 : LV);
        localparam int LATX = (LV + RE - 1) / RE + 1;

        logic         rst_i, in_valid_i, in_ready_o, cin_i, sub_i;
        logic         out_valid_o, out_ready_i, cout_o, ovf_o, zero_o;
        logic [W-1:0] a_i, b_i, sum_o;
        logic [3:0]   tag_i, tag_o;

        prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(RE), .TAG_W(4)) dut (
            .clk(clk), .rst_n(rst_i), .in_valid(in_valid_i), .in_ready(in_ready_o),
            .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i), .tag_in(tag_i),
            .out_valid(out_valid_o), .out_ready(out_ready_i), .sum(sum_o),
            .cout(cout_o), .ovf(ovf_o), .zero(zero_o), .tag_out(tag_o)
        );

        exp_t         q[$];
        int           cyc = 0;
        int           stall_cnt = 0;
        logic         prev_stall = 1'b0;
        logic         head_seen = 1'b0;
        logic [W-1:0] prev_sum;
        logic [7:0]   prev_flags;

        // Compare process: handshake, stall stability, latency and results.
        always @(negedge clk) begin
            exp_t e;
            logic st;
            if (!rst_i) begin
                q.delete();
                prev_stall = 1'b0;
                head_seen  = 1'b0;
            end else begin
                chk("in_ready", g, 64'(in_ready_o), 64'(!(out_valid_o && !out_ready_i)));
                if (prev_stall) begin
                    chk("stall_sum_stable", g, 64'(sum_o), 64'(prev_sum));
                    chk("stall_flags_stable", g, 64'({out_valid_o, cout_o, ovf_o, zero_o, tag_o}), 64'(prev_flags));
                end
                if (out_valid_o) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", g, 64'(out_valid_o), 64'd0);
                    end else begin
                        e = q[0];
                        if (!head_seen) begin
                            chk("latency", g, 64'(cyc - e.acc - (stall_cnt - e.snap)), 64'(LATX));
                            head_seen = 1'b1;
                        end
                        chk("sum", g, 64'(sum_o), e.sum);
                        chk("cout", g, 64'(cout_o), 64'(e.cout));
                        chk("ovf", g, 64'(ovf_o), 64'(e.ovf));
                        chk("zero", g, 64'(zero_o), 64'(e.zero));
                        chk("tag", g, 64'(tag_o), 64'(e.tag));
                        if (out_ready_i) begin
                            void'(q.pop_front());
                            head_seen = 1'b0;
                            consumed_cnt[g]++;
                        end
                    end
                end
                st = out_valid_o && !out_ready_i;
                if (st) stall_cnt++;
                prev_stall = st;
                prev_sum   = sum_o;
                prev_flags = {out_valid_o, cout_o, ovf_o, zero_o, tag_o};
                if (in_valid_i && in_ready_o) begin
                    e      = model(64'(a_i), 64'(b_i), cin_i, sub_i, 8'(tag_i), W);
                    e.acc  = cyc;
                    e.snap = stall_cnt;
                    q.push_back(e);
                end
            end
            cyc++;
        end

        if (g == 0) begin : drv_main
            assign rst_i       = m_rst_n;
            assign in_valid_i  = m_in_valid;
            assign a_i         = m_a;
            assign b_i         = m_b;
            assign cin_i       = m_cin;
            assign sub_i       = m_sub;
            assign tag_i       = m_tag;
            assign out_ready_i = m_out_ready;
            assign m_in_ready  = in_ready_o;
            assign m_out_valid = out_valid_o;
            assign m_sum       = sum_o;
            assign m_cout      = cout_o;
            assign m_ovf       = ovf_o;
            assign m_zero      = zero_o;
            assign m_tag_out   = tag_o;
        end else begin : drv_rand
            assign rst_i = sw_rst_n;
            // Random operations with random backpressure, then drain.
            initial begin
                int n_acc;
                int guard;
                in_valid_i  = 1'b0;
                out_ready_i = 1'b0;
                a_i         = '0;
                b_i         = '0;
                cin_i       = 1'b0;
                sub_i       = 1'b0;
                tag_i       = '0;
                repeat (4) @(posedge clk);
                #1;
                n_acc = 0;
                for (guard = 0; guard < 20000 && n_acc < 1000; guard++) begin
                    in_valid_i  = ($urandom_range(0, 3) != 0);
                    a_i         = W'({$urandom, $urandom});
                    b_i         = W'({$urandom, $urandom});
                    cin_i       = 1'($urandom_range(0, 1));
                    sub_i       = 1'($urandom_range(0, 1));
                    tag_i       = 4'($urandom);
                    out_ready_i = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (in_valid_i && in_ready_o) n_acc++;
                    @(posedge clk);
                    #1;
                end
                in_valid_i  = 1'b0;
                out_ready_i = 1'b1;
                repeat (LATX + 5) @(posedge clk);
                #1;
                chk("sweep_accepted", g, 64'(n_acc), 64'd1000);
                chk("sweep_drain", g, 64'(consumed_cnt[g]), 64'(n_acc));
                sweep_done++;
            end
        end
    end

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic sub, input logic [3:0] tag, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez, input string nm);
        int n;
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_tag = tag; m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        n = 1;
        while (!m_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, 0, 64'(n), 64'd4);
        chk({nm, "_sum"}, 0, 64'(m_sum), 64'(es));
        chk({nm, "_cout"}, 0, 64'(m_cout), 64'(ec));
        chk({nm, "_ovf"}, 0, 64'(m_ovf), 64'(eo));
        chk({nm, "_zero"}, 0, 64'(m_zero), 64'(ez));
        chk({nm, "_tag"}, 0, 64'(m_tag_out), 64'(tag));
        @(posedge clk); #1;
    endtask

    initial begin
        int issued;
        int rc0;
        m_rst_n = 1'b0; sw_rst_n = 1'b0;
        m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_tag = '0;
        m_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_rst_n = 1'b1; sw_rst_n = 1'b1;
        chk("rst_out_valid", 0, 64'(m_out_valid), 64'd0);
        chk("rst_sum", 0, 64'(m_sum), 64'd0);
        chk("rst_flags", 0, 64'({m_cout, m_ovf, m_zero, m_tag_out}), 64'd0);
        chk("rst_in_ready", 0, 64'(m_in_ready), 64'd1);

        // Back-to-back pair: outputs in cycles 4 and 5.
        m_a = 32'hFFFF_FFFF; m_b = 32'd1; m_cin = 1'b0; m_sub = 1'b0; m_tag = 4'd3; m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_a = 32'h7FFF_FFFF; m_b = 32'd1; m_tag = 4'd4;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("tp_c3_valid", 0, 64'(m_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("tp_c4_valid", 0, 64'(m_out_valid), 64'd1);
        chk("tp1_sum", 0, 64'(m_sum), 64'd0);
        chk("tp1_cout", 0, 64'(m_cout), 64'd1);
        chk("tp1_zero", 0, 64'(m_zero), 64'd1);
        chk("tp1_ovf", 0, 64'(m_ovf), 64'd0);
        chk("tp1_tag", 0, 64'(m_tag_out), 64'd3);
        @(posedge clk); #1;
        chk("tp_c5_valid", 0, 64'(m_out_valid), 64'd1);
        chk("tp2_sum", 0, 64'(m_sum), 64'h8000_0000);
        chk("tp2_ovf", 0, 64'(m_ovf), 64'd1);
        chk("tp2_cout", 0, 64'(m_cout), 64'd0);
        chk("tp2_zero", 0, 64'(m_zero), 64'd0);
        chk("tp2_tag", 0, 64'(m_tag_out), 64'd4);
        @(posedge clk); #1;
        chk("tp_c6_valid", 0, 64'(m_out_valid), 64'd0);

        run_one(32'd5, 32'd7, 1'b1, 1'b1, 4'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_5_7");
        run_one(32'd7, 32'd7, 1'b0, 1'b1, 4'd6, 32'd0, 1'b1, 1'b0, 1'b1, "sub_7_7");
        run_one(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 4'd7, 32'd0, 1'b1, 1'b0, 1'b1, "chain");
        run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'd8, 32'd0, 1'b1, 1'b1, 1'b1, "neg_ovf");

        // Backpressure: ten operations, out_ready low for three cycles.
        rc0 = consumed_cnt[0];
        issued = 0;
        for (int j = 0; j < 40 && issued < 10; j++) begin
            m_out_ready = !(j >= 5 && j < 8);
            m_in_valid  = 1'b1;
            m_a = $urandom; m_b = $urandom;
            m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
            m_tag = 4'(issued);
            @(negedge clk);
            if (!m_out_ready) chk("bp_in_ready_low", 0, 64'(m_in_ready), 64'd0);
            if (m_in_ready) issued++;
            @(posedge clk); #1;
        end
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_results", 0, 64'(consumed_cnt[0] - rc0), 64'd10);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            m_a = 32'(100 + i); m_b = 32'd1; m_cin = 1'b0; m_sub = 1'b0; m_tag = 4'(9 + i); m_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        m_in_valid = 1'b0; m_rst_n = 1'b0;
        @(posedge clk); #1;
        m_rst_n = 1'b1;
        chk("rst_mid_valid", 0, 64'(m_out_valid), 64'd0);
        chk("rst_mid_sum", 0, 64'(m_sum), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rst_no_leak", 0, 64'(m_out_valid), 64'd0);
        end
        run_one(32'd1, 32'd2, 1'b0, 1'b0, 4'd1, 32'd3, 1'b0, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 40000 && sweep_done < 6; i++) @(posedge clk);
        chk("sweep_finished", 0, 64'(sweep_done), 64'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined successor of the team's 32-bit kill/generate/propagate (kgp) recursive-doubling adder.
- Computes A+B+cin or A-B with a Kogge-Stone carry prefix of log2(WIDTH) levels.
- Pipeline registers sit at a configurable prefix-level interval.
- Has a valid/ready handshake on both sides, a tag passthrough, and carry/overflow/zero flags.
- Sits in the DCT datapath as the shared add/sub unit feeding the butterfly and accumulation stages.

Parameters:
- WIDTH, 32, operand and sum width; any power of two from 4 to 64.
- REG_EVERY, 2, number of prefix levels between pipeline registers; range 1 to LEVELS.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- Derived, not overridable: LEVELS = log2(WIDTH); LAT = ceil(LEVELS/REG_EVERY) + 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 = A+B+cin; 1 = A-B, computed as A + ~B + 1.
- tag_in  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result bits.
- cout  out  1  carry out of the MSB. For sub this is the not-borrow: 1 when A >= B unsigned.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.
- tag_out  out  TAG_W  tag of the current result.

Behaviour:
- Stage 0, the first register stage:
  - Capture a, b' (b' = b XOR {WIDTH{sub}}), the effective carry-in (sub ? 1 : cin), and tag_in.
  - Form per-bit kgp codes: 00 kill, 01 propagate, 11 generate. Bit position -1 holds the effective carry-in (11 if 1, 00 if 0).
- Prefix levels:
  - Level k combines each position i with position i - 2^k. Positions below index 2^k pass through unchanged.
  - The combine operator: if the upper code is propagate, the result is the lower code; otherwise it is the upper code.
- Pipeline registers:
  - A register bank follows every REG_EVERY prefix levels.
  - The final bank also computes sum[i] = a[i] ^ b'[i] ^ carry[i-1], plus cout, ovf = carry[W-1] ^ carry[W-2], and zero.
- Latency: exactly LAT cycles from in_valid && in_ready to the matching out_valid, when no stall occurs. For WIDTH=32, REG_EVERY=2, LAT = 4.
- Throughput: one operation per cycle.
- Stall and handshake:
  - stall = out_valid && !out_ready.
  - While stalled, all pipeline registers, including valid bits, hold their value. in_ready = !stall.
  - Bubbles are not collapsed; the pipeline is a global-stall shift.
  - Outputs remain stable while out_valid && !out_ready.
- Valid bits: each stage carries a valid bit. An input accepted with in_valid=0 inserts a bubble. out_valid equals the last-stage valid bit.
- Reset, rst_n=0 sampled at a rising edge:
  - All valid bits clear. sum, cout, ovf, zero, tag_out are 0. in_ready = 1 in the cycle after reset.
  - In-flight operations are discarded with no partial output.
  - Reset has priority over stall.
- Wrap-around: the sum is modulo 2^WIDTH; no saturation.
- Simultaneous input accept and output consume is legal every cycle.

Test Plan:
- Throughput: WIDTH=32, REG_EVERY=2. Issue a=0xFFFFFFFF, b=1, cin=0, sub=0, tag=3 back-to-back with a=0x7FFFFFFF, b=1, tag=4. Expected results:
  - First: sum=0, cout=1, zero=1, ovf=0, tag_out=3, out_valid in cycle 4.
  - Second: sum=0x80000000, ovf=1, cout=0, tag_out=4 in cycle 5.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=7, sub=1 -> sum=0, cout=1, zero=1.
- Full carry chain: a=0xAAAAAAAA, b=0x55555555, cin=1 -> sum=0, cout=1. This drives propagate through all 32 positions via every prefix level.
- Backpressure: stream 10 random operations with out_ready low for 3 cycles mid-stream. Expected: in_ready low exactly while out_valid && !out_ready; outputs stable during the stall; all 10 results in order and equal to the reference model; none lost or duplicated.
- Reset mid-operation: assert rst_n=0 for one cycle with 3 operations in flight. Expected: the following cycle has out_valid=0 and sum=0; none of the 3 results ever emerges; a new operation (a=1, b=2) gives sum=3 after LAT cycles.
- Parameter sweep: WIDTH in {4,16,64} and REG_EVERY in {1, LEVELS}, 1000 random operations each with random sub/cin and random out_ready. Expected: results match (a ± b + cin) mod 2^WIDTH, flags correct, latency = LAT.
